pcw_loader_sink: RTL

Core-side receiver for the boot-loader download stream (`dn_go` / `dn_wr` / `dn_addr` / `dn_data` / `execute_enable` / `execute_addr`) that the top level generates after every reset. It buffers incoming bytes in a small FIFO and writes them into system RAM through a request/acknowledge port. While a load is in progress it holds the Z80 off the bus. Once the image is fully written it restarts the CPU at the requested execute address.

---
 rtl/pcw_loader_if.sv | 38 +++
 rtl/pcw_loader_sink.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcw_loader_if.sv
// Boot-loader download stream, RAM write port and CPU control bundle for pcw_loader_sink.
interface pcw_loader_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    logic              dn_go;
    logic              dn_wr;
    logic [ADDR_W-1:0] dn_addr;
    logic [DATA_W-1:0] dn_data;
    logic              execute_enable;
    logic [ADDR_W-1:0] execute_addr;

    logic              ram_req;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ack;

    logic              cpu_hold;
    logic              cpu_reset;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] byte_count;
    logic              overflow;
    logic              busy;

    // Sink side: consumes the download stream, drives RAM and CPU control.
    modport slave (
        input  dn_go, dn_wr, dn_addr, dn_data, execute_enable, execute_addr, ram_ack,
        output ram_req, ram_addr, ram_wdata, cpu_hold, cpu_reset, start_addr,
        output byte_count, overflow, busy
    );

    // Source side: the loader stream, the RAM acknowledge and status observer.
    modport master (
        output dn_go, dn_wr, dn_addr, dn_data, execute_enable, execute_addr, ram_ack,
        input  ram_req, ram_addr, ram_wdata, cpu_hold, cpu_reset, start_addr,
        input  byte_count, overflow, busy
    );
endinterface

// File: rtl/pcw_loader_sink.sv
// Receives the boot-loader byte stream, queues it in a small FIFO, writes it to
// RAM through a req/ack port, holds the CPU during the load and restarts it.
module pcw_loader_sink #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned RESET_CYCLES = 4
) (
    input logic          clk_sys,
    input logic          reset_n,
    pcw_loader_if.slave  bus
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            clear_stats;
    logic            enter_exec;

    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    entry_t          push_entry;
    entry_t          head_next;
    logic            fifo_full;
    logic            wr_in_load;
    logic            push;
    logic            pop;
    logic            drop;

    logic            exec_pending;
    logic [RW-1:0]   exec_cnt;

    logic            ram_req_q;
    entry_t          head_q;
    logic            cpu_hold_q;
    logic            cpu_reset_q;
    logic            busy_q;
    logic [15:0]     start_addr_q;
    logic [15:0]     byte_count_q;
    logic            overflow_q;

    // FIFO push/pop decisions; a full FIFO still accepts a byte when the head leaves the same cycle.
    always_comb begin
        push_entry = '{addr: bus.dn_addr, data: bus.dn_data};
        fifo_full  = (count == CW'(FIFO_DEPTH));
        pop        = bus.ram_ack && (count != '0);
        wr_in_load = (state == S_LOAD) && bus.dn_wr;
        push       = wr_in_load && (!fifo_full || pop);
        drop       = wr_in_load && fifo_full && !pop;
        count_next = count + CW'(push) - CW'(pop);
        rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
    end

    // Entry shown on the RAM port after this edge; a push into an emptied FIFO bypasses the array.
    always_comb begin
        head_next = '0;
        if (count_next != '0) begin
            if ((count - CW'(pop)) == '0) begin
                head_next = push_entry;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; dn_go outranks a pending execute request.
    always_comb begin
        state_next  = state;
        clear_stats = 1'b0;
        enter_exec  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.dn_go) begin
                    state_next  = S_LOAD;
                    clear_stats = 1'b1;
                end else if (exec_pending) begin
                    state_next = S_EXEC;
                    enter_exec = 1'b1;
                end
            end
            S_LOAD: begin
                if (!bus.dn_go) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.dn_go) begin
                    state_next = S_LOAD;
                end else if (count == '0) begin
                    if (exec_pending) begin
                        state_next = S_EXEC;
                        enter_exec = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_EXEC: begin
                if (exec_cnt == RW'(RESET_CYCLES - 1)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Cycles spent in EXEC, restarting from zero on every entry.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            exec_cnt <= '0;
        end else if ((state == S_EXEC) && (state_next == S_EXEC)) begin
            exec_cnt <= exec_cnt + RW'(1);
        end else begin
            exec_cnt <= '0;
        end
    end

    // Execute request latch; a new request in the EXEC-entry cycle survives the clear.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            exec_pending <= 1'b0;
            start_addr_q <= '0;
        end else begin
            if (enter_exec) begin
                exec_pending <= 1'b0;
            end
            if (bus.execute_enable) begin
                exec_pending <= 1'b1;
                start_addr_q <= bus.execute_addr;
            end
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_next;
            count  <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    // Registered RAM request and head entry.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ram_req_q <= 1'b0;
            head_q    <= '0;
        end else begin
            ram_req_q <= (count_next != '0);
            head_q    <= head_next;
        end
    end

    // Load statistics: saturating write counter and sticky drop flag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            byte_count_q <= '0;
            overflow_q   <= 1'b0;
        end else if (clear_stats) begin
            byte_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (pop && (byte_count_q != 16'hFFFF)) begin
                byte_count_q <= byte_count_q + 16'd1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // CPU control levels follow the state being entered.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cpu_hold_q  <= 1'b0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cpu_hold_q  <= (state_next != S_IDLE);
            cpu_reset_q <= (state_next == S_EXEC);
            busy_q      <= (state_next != S_IDLE);
        end
    end

    assign bus.ram_req    = ram_req_q;
    assign bus.ram_addr   = head_q.addr;
    assign bus.ram_wdata  = head_q.data;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.busy       = busy_q;
    assign bus.start_addr = start_addr_q;
    assign bus.byte_count = byte_count_q;
    assign bus.overflow   = overflow_q;
endmodule
